// File: rtl/obi_mstr_arbiter_if.sv
// Bus bundle for obi_mstr_arbiter: N master-side OBI ports plus the shared slave port.
// The slave modport is the arbiter's view; master is the environment (masters + slave model).
interface obi_mstr_arbiter_if #(
    parameter int N_MSTR     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [N_MSTR-1:0]                     m_req;
    logic [N_MSTR-1:0]                     m_gnt;
    logic [N_MSTR-1:0][ADDR_WIDTH-1:0]     m_addr;
    logic [N_MSTR-1:0]                     m_we;
    logic [N_MSTR-1:0][DATA_WIDTH/8-1:0]   m_be;
    logic [N_MSTR-1:0][DATA_WIDTH-1:0]     m_wdata;
    logic [N_MSTR-1:0]                     m_rvalid;
    logic [DATA_WIDTH-1:0]                 m_rdata;
    logic                                  m_err;
    logic                                  s_req;
    logic                                  s_gnt;
    logic [ADDR_WIDTH-1:0]                 s_addr;
    logic                                  s_we;
    logic [DATA_WIDTH/8-1:0]               s_be;
    logic [DATA_WIDTH-1:0]                 s_wdata;
    logic                                  s_rvalid;
    logic [DATA_WIDTH-1:0]                 s_rdata;
    logic                                  s_err;
    logic                                  proto_err;

    modport slave (
        input  m_req, m_addr, m_we, m_be, m_wdata, s_gnt, s_rvalid, s_rdata, s_err,
        output m_gnt, m_rvalid, m_rdata, m_err, s_req, s_addr, s_we, s_be, s_wdata, proto_err
    );

    modport master (
        output m_req, m_addr, m_we, m_be, m_wdata, s_gnt, s_rvalid, s_rdata, s_err,
        input  m_gnt, m_rvalid, m_rdata, m_err, s_req, s_addr, s_we, s_be, s_wdata, proto_err
    );
endinterface

// File: rtl/obi_mstr_arbiter.sv
// N-master to 1-slave OBI arbiter with an in-order routing FIFO for R-channel responses.
// Define OBI_MSTR_ARBITER_RR_EN for round-robin arbitration (default: fixed priority, index 0 highest).
module obi_mstr_arbiter #(
    parameter int N_MSTR          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    obi_mstr_arbiter_if.slave     io_bus
);
    localparam int IDX_W = (N_MSTR > 1) ? $clog2(N_MSTR) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lock;
    logic [IDX_W-1:0] r_lock_idx;
    logic             r_proto_err;

    logic [IDX_W-1:0] w_arb, w_win, w_head;
    logic             w_any, w_full, w_empty, w_sreq, w_accept, w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_any    = |io_bus.m_req;
    assign w_full   = (r_cnt == CNT_W'(MAX_OUTSTANDING));
    assign w_empty  = (r_cnt == '0);
    assign w_head   = r_fifo[r_rptr];
    // A stalled request keeps its master until granted (OBI address-phase stability).
    assign w_win    = r_lock ? r_lock_idx : w_arb;
    assign w_sreq   = reset_n & w_any & ~w_full;
    assign w_accept = w_sreq & io_bus.s_gnt;
    assign w_pop    = reset_n & io_bus.s_rvalid & ~w_empty;

`ifdef OBI_MSTR_ARBITER_RR_EN
    logic [IDX_W-1:0] r_rr_ptr;

    always_comb begin
        int v_idx;
        v_idx = 0;
        w_arb = r_rr_ptr;
        // Scan downward so the nearest requester at/after r_rr_ptr is the last (winning) write.
        for (int k = N_MSTR - 1; k >= 0; k--) begin
            v_idx = (int'(r_rr_ptr) + k) % N_MSTR;
            if (io_bus.m_req[v_idx]) w_arb = IDX_W'(v_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_rr_ptr <= '0;
        else if (w_accept)
            r_rr_ptr <= (w_win == IDX_W'(N_MSTR - 1)) ? '0 : w_win + 1'b1;
    end
`else
    always_comb begin
        w_arb = '0;
        for (int i = N_MSTR - 1; i >= 0; i--)
            if (io_bus.m_req[i]) w_arb = IDX_W'(i);
    end
`endif

    always_comb begin
        io_bus.s_req    = w_sreq;
        io_bus.s_addr   = '0;
        io_bus.s_we     = 1'b0;
        io_bus.s_be     = '0;
        io_bus.s_wdata  = '0;
        io_bus.m_gnt    = '0;
        io_bus.m_rvalid = '0;
        if (reset_n && w_any) begin
            io_bus.s_addr  = io_bus.m_addr[w_win];
            io_bus.s_we    = io_bus.m_we[w_win];
            io_bus.s_be    = io_bus.m_be[w_win];
            io_bus.s_wdata = io_bus.m_wdata[w_win];
        end
        if (w_accept) io_bus.m_gnt[w_win] = 1'b1;
        if (w_pop)    io_bus.m_rvalid[w_head] = 1'b1;
    end

    assign io_bus.m_rdata   = reset_n ? io_bus.s_rdata : '0;
    assign io_bus.m_err     = reset_n & io_bus.s_err;
    assign io_bus.proto_err = r_proto_err;

    always_ff @(posedge clk) begin
        if (w_accept) r_fifo[r_wptr] <= w_win;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_lock      <= 1'b0;
            r_lock_idx  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)    r_rptr <= ptr_inc(r_rptr);
            if (w_accept && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_accept && w_pop) r_cnt <= r_cnt - 1'b1;
            if (w_sreq && !io_bus.s_gnt) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_win;
            end else if (w_accept) begin
                r_lock     <= 1'b0;
            end
            if (io_bus.s_rvalid && w_empty) r_proto_err <= 1'b1;
        end
    end
endmodule
